// File: rtl/imem_pkg.sv
// imem_pkg: shared definitions for the Y86-64 instruction-memory loader.
//   IMEM_BYTES / IMEM_ADDR_W : instruction store geometry.
//   loader_state_e           : loader FSM states. CSUM exists only when
//                              IMEM_LOADER_CSUM_EN is defined.
//   Y86 icode constants      : upper nibble of the first instruction byte.
package imem_pkg;

   localparam int IMEM_BYTES  = 2048;
   localparam int IMEM_ADDR_W = 11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR0,
      ST_HDR1,
      ST_HDR2,
      ST_HDR3,
      ST_DATA,
`ifdef IMEM_LOADER_CSUM_EN
      ST_CSUM,
`endif
      ST_DONE
   } loader_state_e;

   localparam logic [3:0] HALT   = 4'h0;
   localparam logic [3:0] NOP    = 4'h1;
   localparam logic [3:0] RRMOVQ = 4'h2;
   localparam logic [3:0] IRMOVQ = 4'h3;
   localparam logic [3:0] RMMOVQ = 4'h4;
   localparam logic [3:0] MRMOVQ = 4'h5;
   localparam logic [3:0] OPQ    = 4'h6;
   localparam logic [3:0] JXX    = 4'h7;
   localparam logic [3:0] CALL   = 4'h8;
   localparam logic [3:0] RET    = 4'h9;
   localparam logic [3:0] PUSHQ  = 4'hA;
   localparam logic [3:0] POPQ   = 4'hB;

endpackage

// File: rtl/imem_hdr_parse.sv
// imem_hdr_parse: assembles the 4-byte little-endian frame header.
//   clk, reset   : clock, synchronous active-high reset
//   hdr_xfer_i   : a header byte transfers this cycle
//   hdr_idx_i    : which header byte (0,1 = start lo/hi; 2,3 = length lo/hi)
//   hdr_byte_i   : the byte itself
//   start_o      : captured start address
//   len_o        : captured length
//   len_now_o    : length including the byte currently on hdr_byte_i as the
//                  high byte; valid while the last header byte is offered
//   range_err_o  : start + len_now_o exceeds MEM_BYTES (17-bit, no wrap)
module imem_hdr_parse
   import imem_pkg::*;
#(
   parameter int MEM_BYTES = IMEM_BYTES
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        hdr_xfer_i,
   input  logic [1:0]  hdr_idx_i,
   input  logic [7:0]  hdr_byte_i,
   output logic [15:0] start_o,
   output logic [15:0] len_o,
   output logic [15:0] len_now_o,
   output logic        range_err_o
);

   logic [15:0] start_q;
   logic [15:0] len_q;
   logic [16:0] end_addr;

   always_ff @(posedge clk) begin
      if (reset) begin
         start_q <= '0;
         len_q   <= '0;
      end else if (hdr_xfer_i) begin
         unique case (hdr_idx_i)
            2'd0: start_q[7:0]  <= hdr_byte_i;
            2'd1: start_q[15:8] <= hdr_byte_i;
            2'd2: len_q[7:0]    <= hdr_byte_i;
            2'd3: len_q[15:8]   <= hdr_byte_i;
            default: ;
         endcase
      end
   end

   // The loader decides range and zero-length at the HDR3 transfer itself,
   // so the full length is formed from the byte still on the bus.
   assign len_now_o   = {hdr_byte_i, len_q[7:0]};
   assign end_addr    = {1'b0, start_q} + {1'b0, len_now_o};
   assign range_err_o = end_addr > 17'(MEM_BYTES);
   assign start_o     = start_q;
   assign len_o       = len_q;

endmodule

// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream loader driving the instruction store write
// port. Frame = start(16, LE), length(16, LE), payload bytes, and a trailing
// XOR checksum byte when IMEM_LOADER_CSUM_EN is defined.
//   clk, reset         : clock, synchronous active-high reset
//   load_start         : begins a load (IDLE only), clears load_error
//   in_valid/in_byte   : stream input; in_ready says it is accepted
//   wr_en/addr/data    : store write, one cycle after the byte transfer
//   cpu_hold           : high whenever the loader is not IDLE
//   load_done          : one-cycle pulse at frame end
//   load_error         : sticky range / checksum error
//
// state | meaning
// IDLE  | waiting for load_start
// HDR0  | start address low byte
// HDR1  | start address high byte
// HDR2  | length low byte
// HDR3  | length high byte; range check, zero-length shortcut
// DATA  | payload bytes, written while in range, dropped otherwise
// CSUM  | checksum byte (IMEM_LOADER_CSUM_EN only)
// DONE  | load_done pulse, then back to IDLE
module imem_loader
   import imem_pkg::*;
#(
   parameter int MEM_BYTES = IMEM_BYTES,
   parameter int ADDR_W    = IMEM_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_start,
   input  logic              in_valid,
   input  logic [7:0]        in_byte,
   output logic              in_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic              cpu_hold,
   output logic              load_done,
   output logic              load_error
);

   loader_state_e     state_q;
   logic [15:0]       offset_q;
   logic              wr_en_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [7:0]        wr_data_q;
   logic              load_done_q;
   logic              load_error_q;
`ifdef IMEM_LOADER_CSUM_EN
   logic [7:0]        csum_q;
`endif

   logic        xfer;
   logic        hdr_xfer;
   logic [1:0]  hdr_idx;
   logic [15:0] start;
   logic [15:0] len;
   logic [15:0] len_now;
   logic        range_err;
   logic [16:0] addr17;
   logic        in_range;
   logic        last_byte;

   always_comb begin
      in_ready = 1'b0;
      hdr_idx  = 2'd0;
      unique case (state_q)
         ST_HDR0: begin in_ready = 1'b1; hdr_idx = 2'd0; end
         ST_HDR1: begin in_ready = 1'b1; hdr_idx = 2'd1; end
         ST_HDR2: begin in_ready = 1'b1; hdr_idx = 2'd2; end
         ST_HDR3: begin in_ready = 1'b1; hdr_idx = 2'd3; end
         ST_DATA: in_ready = 1'b1;
`ifdef IMEM_LOADER_CSUM_EN
         ST_CSUM: in_ready = 1'b1;
`endif
         default: ;
      endcase
   end

   assign xfer     = in_valid && in_ready;
   assign hdr_xfer = xfer && (state_q inside {ST_HDR0, ST_HDR1, ST_HDR2, ST_HDR3});

   imem_hdr_parse #(
      .MEM_BYTES (MEM_BYTES)
   ) u_hdr (
      .clk         (clk),
      .reset       (reset),
      .hdr_xfer_i  (hdr_xfer),
      .hdr_idx_i   (hdr_idx),
      .hdr_byte_i  (in_byte),
      .start_o     (start),
      .len_o       (len),
      .len_now_o   (len_now),
      .range_err_o (range_err)
   );

   // 17-bit sum so addresses past the store never alias back into it.
   assign addr17    = {1'b0, start} + {1'b0, offset_q};
   assign in_range  = addr17 < 17'(MEM_BYTES);
   assign last_byte = offset_q == (len - 16'd1);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         offset_q     <= '0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         load_done_q  <= 1'b0;
         load_error_q <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
         csum_q       <= '0;
`endif
      end else begin
         wr_en_q     <= 1'b0;
         load_done_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (load_start) begin
                  state_q      <= ST_HDR0;
                  load_error_q <= 1'b0;
               end
            end
            ST_HDR0: if (xfer) state_q <= ST_HDR1;
            ST_HDR1: if (xfer) state_q <= ST_HDR2;
            ST_HDR2: if (xfer) state_q <= ST_HDR3;
            ST_HDR3: begin
               if (xfer) begin
                  offset_q <= '0;
`ifdef IMEM_LOADER_CSUM_EN
                  csum_q   <= '0;
`endif
                  if (range_err) load_error_q <= 1'b1;
                  if (len_now == 16'd0) begin
`ifdef IMEM_LOADER_CSUM_EN
                     state_q     <= ST_CSUM;
`else
                     state_q     <= ST_DONE;
                     load_done_q <= 1'b1;
`endif
                  end else begin
                     state_q <= ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               if (xfer) begin
                  offset_q <= offset_q + 16'd1;
`ifdef IMEM_LOADER_CSUM_EN
                  csum_q   <= csum_q ^ in_byte;
`endif
                  if (in_range) begin
                     wr_en_q   <= 1'b1;
                     wr_addr_q <= addr17[ADDR_W-1:0];
                     wr_data_q <= in_byte;
                  end
                  if (last_byte) begin
`ifdef IMEM_LOADER_CSUM_EN
                     state_q     <= ST_CSUM;
`else
                     state_q     <= ST_DONE;
                     load_done_q <= 1'b1;
`endif
                  end
               end
            end
`ifdef IMEM_LOADER_CSUM_EN
            ST_CSUM: begin
               if (xfer) begin
                  if (in_byte != csum_q) load_error_q <= 1'b1;
                  state_q     <= ST_DONE;
                  load_done_q <= 1'b1;
               end
            end
`endif
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign wr_en      = wr_en_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign load_done  = load_done_q;
   assign load_error = load_error_q;
   assign cpu_hold   = state_q != ST_IDLE;

endmodule
